// File: rtl/seq_match_arbiter_pkg.sv
// Shared types for the serial-pattern matcher: FSM encoding and the
// round-robin pointer advance used by the arbiter.
package seq_match_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int RR_N = 4;
  localparam int RR_W = $clog2(RR_N);

  function automatic logic [RR_W-1:0] next_rr(input logic [RR_W-1:0] g);
    return (g == RR_W'(RR_N - 1)) ? '0 : g + 1'b1;
  endfunction

endpackage

// File: rtl/seq_match_arbiter_if.sv
// Requester/detection bus of the shared matcher: per-channel bit offers,
// one-hot grants, detection pulses and the counter read port.
interface seq_match_arbiter_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]  req_valid;
  logic [N_CH-1:0]  req_bit;
  logic [N_CH-1:0]  req_ready;
  logic             match_valid;
  logic [CH_W-1:0]  match_ch;
  logic [CH_W-1:0]  cnt_sel;
  logic [CNT_W-1:0] cnt_data;

  modport master (
    output req_valid, req_bit, cnt_sel,
    input  req_ready, match_valid, match_ch, cnt_data
  );

  modport slave (
    input  req_valid, req_bit, cnt_sel,
    output req_ready, match_valid, match_ch, cnt_data
  );
endinterface

// File: rtl/seq_match_arbiter_rr.sv
// Round-robin grant: first requester at or after the pointer, wrapping;
// the pointer moves past the winner only when a grant is issued.
module rr_arbiter
  import seq_match_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] gidx
);
  localparam int W = $clog2(N);

  if (N != RR_N) begin : g_bad_n
    $error("rr_arbiter: N must equal seq_match_pkg::RR_N");
  end

  logic [W-1:0] ptr;
  logic         found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        grant[(int'(ptr) + i) % N] = 1'b1;
        gidx = W'((int'(ptr) + i) % N);
      end
    end
  end

  // a grant implies its requester is valid, so any grant is an accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ptr <= '0;
    else if (found)  ptr <= next_rr(gidx);
  end

endmodule

// File: rtl/seq_match_arbiter.sv
// One programmable pattern matcher time-shared by N_CH serial streams;
// per-channel history, fill level and saturating match counters.
module seq_match_arbiter
  import seq_match_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int PAT_LEN = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_load,
  input  logic               enable,
  output logic [1:0]         state_o,
  seq_match_arbiter_if.slave bus
);
  localparam int CH_W   = $clog2(N_CH);
  localparam int FILL_W = $clog2(PAT_LEN + 1);

  state_t                         state;
  logic [PAT_LEN-1:0]             pat;
  logic                           cfg_ok;

  logic [N_CH-1:0][PAT_LEN-1:0]   hist;
  logic [N_CH-1:0][FILL_W-1:0]    fill;
  logic [N_CH-1:0][CNT_W-1:0]     cnt;

  logic [N_CH-1:0]                grant;
  logic [CH_W-1:0]                gidx;
  logic                           acc;
  logic [PAT_LEN-1:0]             cur_hist;
  logic [PAT_LEN-1:0]             new_hist;
  logic [FILL_W-1:0]              cur_fill;
  logic [FILL_W-1:0]              new_fill;
  logic                           hit;

  rr_arbiter #(.N(N_CH)) u_rr (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .req   (bus.req_valid),
    .grant (grant),
    .gidx  (gidx)
  );

  assign bus.req_ready = grant;
  assign acc           = |(grant & bus.req_valid);

  always_comb begin
    cur_hist = hist[gidx];
    cur_fill = fill[gidx];
    new_hist = {cur_hist[PAT_LEN-2:0], bus.req_bit[gidx]};
    new_fill = (cur_fill == FILL_W'(PAT_LEN)) ? cur_fill : cur_fill + 1'b1;
    hit      = acc && (new_hist == pat) && (new_fill == FILL_W'(PAT_LEN));
  end

  // control FSM plus the registered detection outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pat             <= '0;
      cfg_ok          <= 1'b0;
      bus.match_valid <= 1'b0;
      bus.match_ch    <= '0;
    end else begin
      bus.match_valid <= hit;
      if (hit) bus.match_ch <= gidx;
      case (state)
        IDLE: begin
          if (cfg_load) begin
            pat    <= cfg_pattern;
            cfg_ok <= 1'b1;
            state  <= LOAD;
          end else if (enable && cfg_ok) begin
            state  <= RUN;
          end
        end
        LOAD:    state <= IDLE;
        RUN:     if (!enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // accepts only happen in RUN, so the LOAD clear never races an update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
      cnt  <= '0;
    end else if (state == LOAD) begin
      hist <= '0;
      fill <= '0;
      cnt  <= '0;
    end else if (acc) begin
      hist[gidx] <= new_hist;
      fill[gidx] <= new_fill;
      if (hit && (cnt[gidx] != {CNT_W{1'b1}})) cnt[gidx] <= cnt[gidx] + 1'b1;
    end
  end

  assign bus.cnt_data = (int'(bus.cnt_sel) < N_CH) ? cnt[bus.cnt_sel] : '0;
  assign state_o      = state;

endmodule

// File: tb/tb_seq_match_arbiter.sv
// Directed bench: vector tables for streaming/arbitration plus hand
// sequences for control edges; a second instance has 2-bit counters.
module tb_seq_match_arbiter;

  logic       clk;
  logic       reset;
  logic [4:0] cfg_pattern;
  logic       cfg_load;
  logic       enable;
  logic [3:0] valid;
  logic [3:0] bits;
  logic [1:0] sel;
  logic [1:0] st_a, st_b;

  int checks   = 0;
  int failures = 0;

  seq_match_arbiter_if #(.N_CH(4), .CNT_W(8)) ifa ();
  seq_match_arbiter_if #(.N_CH(4), .CNT_W(2)) ifb ();

  assign ifa.req_valid = valid;
  assign ifa.req_bit   = bits;
  assign ifa.cnt_sel   = sel;
  assign ifb.req_valid = valid;
  assign ifb.req_bit   = bits;
  assign ifb.cnt_sel   = sel;

  seq_match_arbiter #(.N_CH(4), .PAT_LEN(5), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .cfg_pattern(cfg_pattern), .cfg_load(cfg_load),
    .enable(enable), .state_o(st_a), .bus(ifa)
  );

  seq_match_arbiter #(.N_CH(4), .PAT_LEN(5), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .cfg_pattern(cfg_pattern), .cfg_load(cfg_load),
    .enable(enable), .state_o(st_b), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [3:0] b;
    logic [1:0] sel;
    logic [3:0] rdy;
    logic       mv;
    logic [1:0] ch;
    logic [7:0] cnt;
  } vec_t;

  vec_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic [3:0] v, input logic [3:0] b, input logic [1:0] s,
                               input logic [3:0] rdy, input logic mv, input logic [1:0] ch,
                               input logic [7:0] cnt);
    vec_t t;
    t.v = v; t.b = b; t.sel = s; t.rdy = rdy; t.mv = mv; t.ch = ch; t.cnt = cnt;
    q.push_back(t);
  endfunction

  task automatic run_q(input string tag);
    logic [7:0] sat;
    for (int i = 0; i < q.size(); i++) begin
      valid = q[i].v;
      bits  = q[i].b;
      sel   = q[i].sel;
      #1;
      chk($sformatf("%s[%0d].ready", tag, i), 32'(ifa.req_ready), 32'(q[i].rdy));
      tick();
      chk($sformatf("%s[%0d].mv_a", tag, i), 32'(ifa.match_valid), 32'(q[i].mv));
      chk($sformatf("%s[%0d].mv_b", tag, i), 32'(ifb.match_valid), 32'(q[i].mv));
      if (q[i].mv) begin
        chk($sformatf("%s[%0d].ch_a", tag, i), 32'(ifa.match_ch), 32'(q[i].ch));
        chk($sformatf("%s[%0d].ch_b", tag, i), 32'(ifb.match_ch), 32'(q[i].ch));
      end
      sat = (q[i].cnt > 8'd3) ? 8'd3 : q[i].cnt;
      chk($sformatf("%s[%0d].cnt_a", tag, i), 32'(ifa.cnt_data), 32'(q[i].cnt));
      chk($sformatf("%s[%0d].cnt_b", tag, i), 32'(ifb.cnt_data), 32'(sat));
    end
    q.delete();
    valid = '0;
    bits  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; cfg_pattern = '0;
    valid = 4'b1111; bits = '0; sel = '0;
    tick();
    tick();
    chk("rst.state", 32'(st_a), 32'd0);
    chk("rst.ready", 32'(ifa.req_ready), 32'd0);
    chk("rst.mv", 32'(ifa.match_valid), 32'd0);
    chk("rst.ch", 32'(ifa.match_ch), 32'd0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("rst.cnt%0d", s), 32'(ifa.cnt_data), 32'd0);
    end
    valid = '0; sel = '0;
    reset = 1'b0;
    tick();
  endtask

  // cfg_load together with enable: load must win, then RUN follows via IDLE
  task automatic load_and_run(input logic [4:0] p);
    enable = 1'b1; cfg_pattern = p; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("lr.load", 32'(st_a), 32'd1);
    tick();
    chk("lr.idle", 32'(st_a), 32'd0);
    tick();
    chk("lr.run", 32'(st_a), 32'd2);
  endtask

  logic [7:0] sa;
  logic [4:0] s1, s2;
  logic       bt;
  int         k, c;

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; cfg_pattern = '0;
    valid = '0; bits = '0; sel = '0;

    // enable without a prior load must not leave IDLE
    do_reset();
    enable = 1'b1; valid = 4'b1111;
    tick(); tick(); tick();
    chk("noload.state", 32'(st_a), 32'd0);
    chk("noload.ready", 32'(ifa.req_ready), 32'd0);
    valid = '0; enable = 1'b0;
    tick();

    // ch0 alone, 11011011: overlapping matches after accepts 5 and 8
    do_reset();
    load_and_run(5'b11011);
    sa = 8'b11011011;
    for (int i = 0; i < 8; i++)
      push(4'b0001, {3'b000, sa[7-i]}, 2'd0, 4'b0001, (i == 4 || i == 7), 2'd0,
           (i < 4) ? 8'd0 : (i < 7) ? 8'd1 : 8'd2);
    run_q("ch0");

    // ch1 (11011) and ch2 (11101) interleaved; only ch1 matches
    do_reset();
    load_and_run(5'b11011);
    s1 = 5'b11011; s2 = 5'b11101;
    for (int j = 0; j < 10; j++) begin
      k = j / 2;
      push(4'b0110, {1'b0, s2[4-k], s1[4-k], 1'b0}, 2'd1,
           (j % 2 == 0) ? 4'b0010 : 4'b0100, (j == 8), 2'd1, (j >= 8) ? 8'd1 : 8'd0);
    end
    run_q("ilv");
    sel = 2'd2;
    #1;
    chk("ilv.cnt2", 32'(ifa.cnt_data), 32'd0);

    // all four requesting: grant rotates 0,1,2,3,0
    do_reset();
    load_and_run(5'b11011);
    push(4'b1111, 4'b0000, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    push(4'b1111, 4'b0000, 2'd0, 4'b0010, 1'b0, 2'd0, 8'd0);
    push(4'b1111, 4'b0000, 2'd0, 4'b0100, 1'b0, 2'd0, 8'd0);
    push(4'b1111, 4'b0000, 2'd0, 4'b1000, 1'b0, 2'd0, 8'd0);
    push(4'b1111, 4'b0000, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    run_q("rr4");

    // ch3, five overlapping matches: 8-bit counter 1..5, 2-bit saturates at 3
    do_reset();
    load_and_run(5'b11011);
    for (int i = 0; i < 17; i++) begin
      bt = (i % 3 == 2) ? 1'b0 : 1'b1;
      c  = (i >= 4) ? (i - 4) / 3 + 1 : 0;
      push(4'b1000, {bt, 3'b000}, 2'd3, 4'b1000, (i >= 4 && i % 3 == 1), 2'd3, 8'(c));
    end
    run_q("sat");

    // cfg_load in RUN is ignored; enable drop on the last grant still matches
    do_reset();
    load_and_run(5'b11011);
    cfg_pattern = 5'b00000; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("runload.state", 32'(st_a), 32'd2);
    push(4'b0001, 4'b0001, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    push(4'b0001, 4'b0001, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    push(4'b0001, 4'b0000, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    push(4'b0001, 4'b0001, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    run_q("runload");
    valid = 4'b0001; bits = 4'b0001; enable = 1'b0;
    #1;
    chk("endrop.ready", 32'(ifa.req_ready), 32'd1);
    tick();
    valid = '0; bits = '0;
    chk("endrop.mv", 32'(ifa.match_valid), 32'd1);
    chk("endrop.state", 32'(st_a), 32'd0);
    chk("endrop.cnt", 32'(ifa.cnt_data), 32'd1);
    tick();
    chk("endrop.pulse", 32'(ifa.match_valid), 32'd0);

    // reset mid-stream clears history and cfg_ok; reload restarts fill at 0
    do_reset();
    load_and_run(5'b11011);
    push(4'b0001, 4'b0001, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    push(4'b0001, 4'b0001, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    push(4'b0001, 4'b0000, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    run_q("pre");
    reset = 1'b1;
    #1;
    chk("midrst.state", 32'(st_a), 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    tick(); tick();
    chk("midrst.cfgok", 32'(st_a), 32'd0);
    load_and_run(5'b11011);
    push(4'b0001, 4'b0001, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    push(4'b0001, 4'b0001, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    push(4'b0001, 4'b0000, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    push(4'b0001, 4'b0001, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
    push(4'b0001, 4'b0001, 2'd0, 4'b0001, 1'b1, 2'd0, 8'd1);
    run_q("post");

    // leading-zero pattern: a 2-bit history must not match before fill saturates
    enable = 1'b0;
    tick();
    load_and_run(5'b00011);
    push(4'b0010, 4'b0010, 2'd1, 4'b0010, 1'b0, 2'd1, 8'd0);
    push(4'b0010, 4'b0010, 2'd1, 4'b0010, 1'b0, 2'd1, 8'd0);
    push(4'b0010, 4'b0000, 2'd1, 4'b0010, 1'b0, 2'd1, 8'd0);
    push(4'b0010, 4'b0000, 2'd1, 4'b0010, 1'b0, 2'd1, 8'd0);
    push(4'b0010, 4'b0000, 2'd1, 4'b0010, 1'b0, 2'd1, 8'd0);
    push(4'b0010, 4'b0010, 2'd1, 4'b0010, 1'b0, 2'd1, 8'd0);
    push(4'b0010, 4'b0010, 2'd1, 4'b0010, 1'b1, 2'd1, 8'd1);
    run_q("fill");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_match_arbiter.md
# seq_match_arbiter

Shares one programmable serial-pattern matcher among `N_CH` independent bit-stream requesters. A round-robin arbiter accepts at most one bit per cycle. The block keeps per-channel shift history, fill level and saturating match counters, and reports each detection with its channel number. It sits in front of the sequence-detection datapath and replaces one fixed-pattern detector per stream.

## Interface
- `N_CH`, 4: number of requesters (≥2).
- `PAT_LEN`, 5: pattern length in bits (2..16).
- `CNT_W`, 8: per-channel match counter width.
- `CH_W`, `$clog2(N_CH)`: derived channel-index width (localparam).

- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_pattern` in `PAT_LEN`: pattern, MSB is the first bit received.
- `cfg_load` in 1: load `cfg_pattern` (accepted in IDLE only).
- `enable` in 1: level; requests RUN.
- `req_valid` in `N_CH`: per-channel bit offered.
- `req_bit` in `N_CH`: per-channel serial bit.
- `req_ready` out `N_CH`: one-hot grant, combinational; all-zero outside RUN.
- `match_valid` out 1: registered one-cycle detection pulse.
- `match_ch` out `CH_W`: channel of the detection; valid with `match_valid`.
- `cnt_sel` in `CH_W`: counter read select.
- `cnt_data` out `CNT_W`: combinational read of counter `cnt_sel`.
- `state_o` out 2: current FSM state, for monitoring.

## Operation
- FSM states (shared package enum): IDLE=0, LOAD=1, RUN=2.
- IDLE, `cfg_load`=1: latch the pattern, set `cfg_ok`, go to LOAD. `cfg_load` takes precedence over `enable` in the same cycle.
- IDLE, `enable`=1 and `cfg_ok`=1: go to RUN. If `cfg_ok`=0, `enable` is ignored and the block stays in IDLE.
- LOAD (exactly one cycle): clear all histories, fill levels and counters, then go to IDLE.
- RUN: `enable`=0 returns to IDLE next cycle. Histories and counters are kept. `cfg_load` is ignored in RUN.
- Arbitration: the grant goes to the first requesting channel at or after `rr_ptr`, wrapping around. A bit is accepted when `req_valid[g] & req_ready[g]`.
- After an accept on channel g, `rr_ptr` becomes (g+1) mod `N_CH`. With no accept, `rr_ptr` is unchanged.
- On accept:
  - `hist[g]` becomes {`hist[g]`[`PAT_LEN`-2:0], bit}.
  - `fill[g]` increments and saturates at `PAT_LEN`.
- Match condition: the new history equals the pattern and the new fill equals `PAT_LEN`. Overlapping matches count, since history is never cleared on a match.
- On match:
  - `match_valid`=1 and `match_ch`=g on the next cycle.
  - `cnt[g]` increments and saturates at 2^`CNT_W`−1.
- Channels are fully independent. Interleaving never mixes histories.

## Timing
- Reset values:
  - FSM IDLE, `rr_ptr`=0, pattern=0, `cfg_ok`=0.
  - All histories, fill levels and counters 0.
  - `match_valid`=0, `match_ch`=0, `req_ready`=0.
  - `cnt_data` therefore reads 0.
- Latency: accept at edge k gives `match_valid` high for the cycle after edge k, i.e. exactly one cycle, registered.
- Throughput: one bit per cycle aggregate. A sole requester is granted every cycle.
- Counter update is visible on `cnt_data` the cycle after the accept, together with `match_valid`.
- `enable` falling in the same cycle as a grant: that accept completes normally, and its match pulse still issues in IDLE.
- Reset mid-operation clears everything immediately, including `cfg_ok`. A reload is required before RUN.

## Structure
- Package `seq_match_pkg` holds the `state_t` enum (IDLE/LOAD/RUN) and a `next_rr` function. The function's width is a package parameter, and the module asserts it equals `N_CH`.
- One sub-module, `rr_arbiter`: combinational grant from `req_valid`, `rr_ptr` and `en`, plus a registered pointer update. Parameter `N`.
- Histories, fill levels and counters are register arrays indexed by the granted channel.

## Test plan
- Pattern 5'b11011. Ch0 alone streams 11011 → `match_valid`=1 and `match_ch`=0 one cycle after the 5th accept. `cnt_data`(sel 0)=1.
- Ch0 streams 11011011 → two pulses, after accepts 5 and 8. Counter reads 2.
- Ch1 streams 11011 and ch2 streams 11101, both continuously valid → grants alternate 1,2,1,2…. Only ch1 matches. Ch2 counter stays 0.
- All four channels valid every cycle → `req_ready` sequence 0001,0010,0100,1000,0001.
- `CNT_W`=2: five matches on ch3 → counter reads 1,2,3,3,3. A match pulse still occurs each time.
- Control edges:
  - `enable` before any `cfg_load` → stays IDLE, `req_ready`=0.
  - `cfg_load` asserted in RUN → pattern unchanged.
  - Reset after ch0 accepts 110, then reload, RUN, stream 11 → no match (fill=2).
